// File: rtl/accum_drain_if.sv
// accum_drain_if: control, limit and index/strobe signals between the tile sequencer side and the drain controller
interface accum_drain_if #(
  parameter int RW = 3,
  parameter int CW = 3,
  parameter int SW = 4
);
  logic          start;
  logic          abort;
  logic [RW-1:0] num_row_sub_m1;
  logic [CW-1:0] num_col_sub_m1;
  logic          out_ready;
  logic [SW-1:0] sub_row;
  logic [RW-1:0] submat_row_idx;
  logic [CW-1:0] submat_col_idx;
  logic          rd_en;
  logic          out_valid;
  logic          out_last;
  logic          busy;
  logic          done;
  modport master (
    output start, abort, num_row_sub_m1, num_col_sub_m1, out_ready,
    input  sub_row, submat_row_idx, submat_col_idx, rd_en, out_valid, out_last, busy, done
  );
  modport slave (
    input  start, abort, num_row_sub_m1, num_col_sub_m1, out_ready,
    output sub_row, submat_row_idx, submat_col_idx, rd_en, out_valid, out_last, busy, done
  );
endinterface

// File: rtl/accum_drain_ctrl.sv
// accum_drain_ctrl: walks the accumulator table and issues back-pressured read strobes tagged valid/last
module accum_drain_ctrl #(
  parameter int MAX_OUT_ROWS = 128,
  parameter int MAX_OUT_COLS = 128,
  parameter int SYS_ARR_ROWS = 16,
  parameter int SYS_ARR_COLS = 16,
  parameter int RD_LAT       = 1
) (
  input logic          clk,
  input logic          rst_n,
  accum_drain_if.slave bus
);
  localparam int NRS = MAX_OUT_ROWS / SYS_ARR_ROWS;
  localparam int NCS = MAX_OUT_COLS / SYS_ARR_COLS;
  localparam int RW  = $clog2(NRS);
  localparam int CW  = $clog2(NCS);
  localparam int SW  = $clog2(SYS_ARR_ROWS);
  localparam logic [SW-1:0]     S_MAX     = SW'(SYS_ARR_ROWS - 1);
  localparam logic [RD_LAT-1:0] OUT_STAGE = RD_LAT'(1) << (RD_LAT - 1);
  typedef enum logic [1:0] {IDLE, DRAIN, FLUSH, DONE} state_t;
  state_t          state, state_nx;
  logic [RW-1:0]   row, row_lim;
  logic [CW-1:0]   col, col_lim;
  logic [SW-1:0]   sub;
  logic            aborted;
  logic [RD_LAT-1:0] vld_pipe, last_pipe;
  logic            rd, last_beat, drained;
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // read strobe, last-beat tag and next state; FLUSH leaves once only the output stage may still hold a beat
  always_comb begin
    rd        = state == DRAIN && bus.out_ready && !bus.abort;
    last_beat = rd && row == row_lim && col == col_lim && sub == S_MAX;
    drained   = (vld_pipe & ~OUT_STAGE) == '0;
    state_nx  = state;
    case (state)
      IDLE:    state_nx = bus.start ? DRAIN : IDLE;
      DRAIN:   state_nx = (bus.abort || last_beat) ? FLUSH : DRAIN;
      FLUSH:   state_nx = drained ? (aborted ? IDLE : DONE) : FLUSH;
      default: state_nx = IDLE;
    endcase
  end
  // limit latch, abort flag and (row, col, sub) walk with sub innermost
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      row_lim <= '0;
      col_lim <= '0;
      row     <= '0;
      col     <= '0;
      sub     <= '0;
      aborted <= 1'b0;
    end else if (state == IDLE && bus.start) begin
      row_lim <= bus.num_row_sub_m1;
      col_lim <= bus.num_col_sub_m1;
      row     <= '0;
      col     <= '0;
      sub     <= '0;
      aborted <= 1'b0;
    end else if (state == DRAIN && bus.abort) begin
      aborted <= 1'b1;
    end else if (rd) begin
      sub <= sub == S_MAX ? '0 : sub + 1'b1;
      if (sub == S_MAX) begin
        col <= col == col_lim ? '0 : col + 1'b1;
        if (col == col_lim) row <= row + 1'b1;
      end
    end
  // fixed-latency valid/last delay line matching the table read latency
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      vld_pipe  <= '0;
      last_pipe <= '0;
    end else begin
      vld_pipe  <= (vld_pipe << 1) | RD_LAT'(rd);
      last_pipe <= (last_pipe << 1) | RD_LAT'(last_beat);
    end
  assign bus.rd_en          = rd;
  assign bus.out_valid      = vld_pipe[RD_LAT-1];
  assign bus.out_last       = last_pipe[RD_LAT-1];
  assign bus.busy           = state == DRAIN || state == FLUSH;
  assign bus.done           = state == DONE;
  assign bus.sub_row        = sub;
  assign bus.submat_row_idx = row;
  assign bus.submat_col_idx = col;
endmodule

// File: tb/tb_accum_drain_ctrl.sv
// tb_accum_drain_ctrl: drives RD_LAT=1 and RD_LAT=3 instances in lockstep against an index model and valid/last scoreboards
module tb_accum_drain_ctrl;
  localparam int INF = 1 << 30;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;
  accum_drain_if #(.RW(3), .CW(3), .SW(4)) a();
  accum_drain_if #(.RW(3), .CW(3), .SW(4)) b();
  assign b.start          = a.start;
  assign b.abort          = a.abort;
  assign b.num_row_sub_m1 = a.num_row_sub_m1;
  assign b.num_col_sub_m1 = a.num_col_sub_m1;
  assign b.out_ready      = a.out_ready;
  accum_drain_ctrl #(.RD_LAT(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(a.slave));
  accum_drain_ctrl #(.RD_LAT(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(b.slave));
  int checks = 0, errors = 0;
  int cyc = 0;
  int q1[$], q3[$];
  int r, c, s, lr, lc, lrd, sc, b1, b3, nb, nl1, nl3;
  bit mdrain = 0, started = 0, nm = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask
  task automatic step();
    bit er, il, ev;
    @(negedge clk);
    cyc++;
    if (!rst_n) begin
      q1.delete();
      q3.delete();
      mdrain  = 0;
      started = 0;
    end
    er = mdrain && a.out_ready && !a.abort;
    chk("rd_en1", a.rd_en, er);
    chk("rd_en3", b.rd_en, er);
    if (er) begin
      chk("idx1", {a.submat_row_idx, a.submat_col_idx, a.sub_row}, {r[2:0], c[2:0], s[3:0]});
      chk("idx3", {b.submat_row_idx, b.submat_col_idx, b.sub_row}, {r[2:0], c[2:0], s[3:0]});
      il = r == lr && c == lc && s == 15;
      q1.push_back((cyc + 1) * 2 + int'(il));
      q3.push_back((cyc + 3) * 2 + int'(il));
      nb++;
      lrd = cyc;
      if (s == 15) begin
        s = 0;
        if (c == lc) begin c = 0; r++; end else c++;
      end else s++;
      if (il) begin mdrain = 0; b1 = cyc + 2; b3 = cyc + 4; nm = 1; end
    end else if (mdrain && a.abort) begin
      mdrain = 0;
      b1 = (cyc + 2 > lrd + 2) ? cyc + 2 : lrd + 2;
      b3 = (cyc + 2 > lrd + 4) ? cyc + 2 : lrd + 4;
      nm = 0;
    end
    if (a.start && rst_n && (!started || cyc >= b3 + int'(nm))) begin
      started = 1; sc = cyc; b1 = INF; b3 = INF; nm = 0; mdrain = 1;
      lr = int'(a.num_row_sub_m1); lc = int'(a.num_col_sub_m1);
      r = 0; c = 0; s = 0; lrd = -100;
    end
    ev = q1.size() > 0 && q1[0] / 2 == cyc;
    chk("valid1", a.out_valid, ev);
    if (ev) begin chk("last1", a.out_last, q1[0] % 2); void'(q1.pop_front()); end
    ev = q3.size() > 0 && q3[0] / 2 == cyc;
    chk("valid3", b.out_valid, ev);
    if (ev) begin chk("last3", b.out_last, q3[0] % 2); void'(q3.pop_front()); end
    chk("done1", a.done, started && nm && cyc == b1);
    chk("done3", b.done, started && nm && cyc == b3);
    chk("busy1", a.busy, started && cyc > sc && cyc < b1);
    chk("busy3", b.busy, started && cyc > sc && cyc < b3);
    if (a.out_valid && a.out_last) nl1++;
    if (b.out_valid && b.out_last) nl3++;
    @(posedge clk);
    #1;
  endtask
  task automatic go(input int rl, input int cl);
    nb = 0; nl1 = 0; nl3 = 0;
    a.num_row_sub_m1 = 3'(rl);
    a.num_col_sub_m1 = 3'(cl);
    a.start = 1'b1;
    step();
    a.start = 1'b0;
  endtask
  task automatic run(input int lim, input bit tog);
    for (int i = 0; i < lim; i++) begin
      if (started && cyc >= b3 + int'(nm)) break;
      if (tog) a.out_ready = (i / 3) % 2 == 0;
      step();
    end
    a.out_ready = 1'b1;
    chk("finish_in_budget", started && cyc >= b3 + int'(nm), 1);
  endtask
  task automatic chk_idx_zero();
    chk("rst_sub1", a.sub_row, 0);
    chk("rst_row1", a.submat_row_idx, 0);
    chk("rst_col1", a.submat_col_idx, 0);
    chk("rst_idx3", {b.submat_row_idx, b.submat_col_idx, b.sub_row}, 0);
  endtask
  initial begin
    rst_n = 1'b0;
    a.start = 1'b0; a.abort = 1'b0; a.out_ready = 1'b1;
    a.num_row_sub_m1 = '0; a.num_col_sub_m1 = '0;
    @(posedge clk); #1;
    step(); step();
    chk_idx_zero();
    rst_n = 1'b1;
    step(); step();
    go(0, 0);
    run(200, 0);
    chk("beats_00", nb, 16); chk("lasts1_00", nl1, 1); chk("lasts3_00", nl3, 1);
    go(1, 2);
    run(500, 0);
    chk("beats_12", nb, 96); chk("lasts1_12", nl1, 1); chk("lasts3_12", nl3, 1);
    go(1, 2);
    a.num_row_sub_m1 = '0; a.num_col_sub_m1 = '0;
    run(1000, 1);
    chk("beats_12_bp", nb, 96); chk("lasts1_12_bp", nl1, 1);
    go(0, 1);
    for (int i = 0; i < 200 && mdrain; i++) step();
    for (int i = 0; i < 20 && cyc + 1 < b1; i++) step();
    a.start = 1'b1;
    step();
    a.start = 1'b0;
    run(200, 0);
    chk("beats_01", nb, 32); chk("lasts3_01", nl3, 1);
    go(0, 0);
    repeat (10) step();
    a.abort = 1'b1;
    step();
    a.abort = 1'b0;
    a.start = 1'b1;
    step();
    a.start = 1'b0;
    run(200, 0);
    chk("beats_abort", nb, 10); chk("lasts1_abort", nl1, 0); chk("lasts3_abort", nl3, 0);
    a.abort = 1'b1;
    step();
    a.abort = 1'b1;
    go(0, 0);
    a.abort = 1'b0;
    run(200, 0);
    chk("beats_start_abort", nb, 16);
    go(0, 0);
    repeat (5) step();
    rst_n = 1'b0;
    step(); step();
    chk_idx_zero();
    rst_n = 1'b1;
    step(); step(); step();
    go(0, 0);
    run(200, 0);
    chk("beats_after_rst", nb, 16); chk("lasts1_after_rst", nl1, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/accum_drain_ctrl.md
Name: accum_drain_ctrl

Overview:
Sequences the drain of the accumulator table once a tile computation finishes. It walks every (submatrix row, submatrix column, sub-row) triple in a fixed order and drives the index inputs of the accumulator read-address generator. It issues read strobes under downstream back-pressure and tags the returning data with valid/last.
It sits between the top-level tile sequencer (start/done) and the output writer toward the unified buffer.

Parameters:
MAX_OUT_ROWS, 128, maximum output matrix rows
MAX_OUT_COLS, 128, maximum output matrix columns
SYS_ARR_ROWS, 16, systolic array rows; sub-rows per submatrix
SYS_ARR_COLS, 16, systolic array columns
RD_LAT, 1, accumulator table read latency in cycles (1..4)
Derived: NRS = MAX_OUT_ROWS/SYS_ARR_ROWS; NCS = MAX_OUT_COLS/SYS_ARR_COLS; RW = $clog2(NRS); CW = $clog2(NCS); SW = $clog2(SYS_ARR_ROWS)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begin drain (ignored unless IDLE)
abort  in  1  terminate drain; return to IDLE after in-flight beats retire
num_row_sub_m1  in  RW  number of submatrix rows minus 1; latched on start
num_col_sub_m1  in  CW  number of submatrix columns minus 1; latched on start
out_ready  in  1  downstream can accept a beat
sub_row  out  SW  sub-row index to the address generator
submat_row_idx  out  RW  submatrix row index
submat_col_idx  out  CW  submatrix column index
rd_en  out  1  accumulator read strobe
out_valid  out  1  read data valid this cycle (rd_en delayed RD_LAT)
out_last  out  1  qualifies out_valid; final beat of the drain
busy  out  1  high from the accepted start until done
done  out  1  one-cycle pulse at completion (not asserted on abort)

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0, RD_LAT valid/last pipeline cleared. Reset mid-drain discards in-flight beats.
- States:
  - IDLE: on start, latch both limits, clear counters, go DRAIN; busy=1 from the next cycle.
  - DRAIN: rd_en = out_ready & ~abort (combinational from registered state and inputs). Index outputs are registered counter values, held while rd_en=0.
    - On rd_en: sub_row increments. On wrap from SYS_ARR_ROWS-1, submat_col_idx increments. On wrap from num_col_sub_m1, submat_row_idx increments.
    - Order: submat_row outer, submat_col middle, sub_row inner.
    - The beat issued at (num_row_sub_m1, num_col_sub_m1, SYS_ARR_ROWS-1) is marked last; the block then goes FLUSH.
    - abort in DRAIN: no further rd_en; go FLUSH with an abort flag set.
  - FLUSH: wait until the valid pipeline is empty (RD_LAT cycles after the last rd_en), then go DONE. If aborted, go IDLE instead, clearing busy with no done pulse.
  - DONE: done=1 for one cycle, busy=0, next state IDLE. A start in the DONE cycle is ignored.
- Pipeline: out_valid and out_last equal rd_en and the last tag delayed by exactly RD_LAT cycles, with no stall.
  - Downstream must absorb up to RD_LAT beats after deasserting out_ready.
  - out_ready has no effect on beats already in flight.
- Total beats = (num_row_sub_m1+1)*(num_col_sub_m1+1)*SYS_ARR_ROWS. Minimum configuration (0,0) yields SYS_ARR_ROWS beats.
- Limit inputs are sampled only on the accepted start; later changes are ignored.
- Counter widths match the index outputs; no overflow is possible because wrap limits are ≤ the maximum representable value.
- abort in IDLE or DONE: no effect. Simultaneous start and abort in IDLE: start is accepted; abort is then evaluated in DRAIN on the next cycle if still high.

Test Plan:
- Reset mid-drain (after 5 beats with out_ready=1), then release -> all outputs 0 and out_valid stays 0 until the next start; a fresh start drains from (0,0,0).
- Defaults, start with limits (0,0), out_ready=1 -> 16 consecutive rd_en with sub_row 0..15 and both submat indices 0. out_valid follows rd_en 1 cycle later, out_last on the 16th out_valid, done pulses 1 cycle after it, busy spans start+1 to done.
- Limits (1,2), out_ready=1 -> 96 beats. Index sequence (r,c,s) runs (0,0,0..15), (0,1,..), (0,2,..), (1,0,..) … (1,2,15). Exactly one out_last.
- Same config, out_ready toggled 1/0 every 3 cycles -> rd_en only when ready. Indices hold while ready=0. The 96-beat count and order are unchanged.
- RD_LAT=3, limits (0,1), out_ready=1 -> out_valid lags rd_en by 3 cycles. done asserts 3 cycles after the final rd_en plus one FLUSH-exit cycle.
- abort asserted after beat 10 of a (0,0) drain -> rd_en stops in the same cycle. The last in-flight out_valid appears at beat 10 with out_last=0. busy falls with no done pulse, and a start while busy is ignored.
